pkt_buf_ram: RTL

// - Parametrised simple dual-port packet buffer RAM: one write port and one read port, both on clk.
// - Holds Ethernet frame data between the MAC datapath (write side) and the AXI fetch engine (read side).
// - Over a flat RAM it adds: byte-lane writes, registered read with valid strobe, selectable read latency,

---
 rtl/pkt_buf_ram.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pkt_buf_ram.sv
// Simple dual-port packet buffer RAM between the MAC write path and the AXI fetch read path.
// Ports:
//   clk, rst (sync, active-high)
//   wr_en/wr_addr/wr_data/wr_be : byte-lane write port
//   rd_en/rd_addr -> rd_data/rd_valid after RD_LAT cycles
//   addr_err (sticky) with clr_err
//   par_err; par_inj exists only when PKT_RAM_PARITY_EN is defined
// Optional feature macro: PKT_RAM_PARITY_EN (per-byte even parity storage and checking).
module pkt_buf_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                addr_err,
    input  logic                clr_err,
`ifdef PKT_RAM_PARITY_EN
    input  logic                par_inj,
`endif
    output logic                par_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             wr_ok, rd_ok, wr_go, fwd;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic             rd_perr;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_perr_q, s1_perr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              par_err_q, par_err_d;
    logic              addr_err_q, addr_err_d;
    logic              src_v, src_p;
    logic [DATA_W-1:0] src_d;

    assign wr_ok  = (wr_addr < DEPTH_A);
    assign rd_ok  = (rd_addr < DEPTH_A);
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_addr[IDX_W-1:0];
    // Writes seen during reset are dropped.
    assign wr_go  = wr_en & wr_ok & ~rst;
    assign fwd    = wr_en & wr_ok & rd_ok & (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Write-first: lanes enabled by a same-address write come from wr_data.
    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < NB; i++) begin
            if (fwd && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
        if (!rd_ok) rd_word = '0;
    end

`ifdef PKT_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par, rd_par, calc_par;

    always_comb begin
        for (int i = 0; i < NB; i++) wr_par[i] = ^wr_data[8*i +: 8];
        wr_par[0] = wr_par[0] ^ par_inj;
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) par_mem[wr_idx][i] <= wr_par[i];
            end
        end
    end

    always_comb begin
        rd_par = par_mem[rd_idx];
        for (int i = 0; i < NB; i++) begin
            if (fwd && wr_be[i]) rd_par[i] = wr_par[i];
            calc_par[i] = ^rd_word[8*i +: 8];
        end
        rd_perr = rd_ok & (|(calc_par ^ rd_par));
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_comb begin
        s1_valid_d = rd_en;
        s1_data_d  = rd_word;
        s1_perr_d  = rd_en & rd_perr;
        if (RD_LAT == 2) begin
            src_v = s1_valid_q;
            src_d = s1_data_q;
            src_p = s1_perr_q;
        end else begin
            src_v = rd_en;
            src_d = rd_word;
            src_p = rd_perr;
        end
        rd_valid_d = src_v;
        rd_data_d  = src_v ? src_d : rd_data_q;
        par_err_d  = src_v & src_p;
        // A new error in the same cycle as clr_err wins.
        addr_err_d = clr_err ? 1'b0 : addr_err_q;
        if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) addr_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_perr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            par_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_perr_q  <= s1_perr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            par_err_q  <= par_err_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign par_err  = par_err_q;
    assign addr_err = addr_err_q;

endmodule
